// File: rtl/fp_to_bcd_if.sv
// Handshake and result bundle for the float-to-BCD converter.
// slave: the converter side. master: the FPU result port / consumer side.
interface fp_to_bcd_if #(
  parameter int INT_DIGITS  = 5,
  parameter int FRAC_DIGITS = 4
);
  logic                     i_valid;
  logic                     o_ready;
  logic [31:0]              i_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_sign;
  logic [4*INT_DIGITS-1:0]  o_int_bcd;
  logic [4*FRAC_DIGITS-1:0] o_frac_bcd;
  logic                     o_zero;
  logic                     o_inf;
  logic                     o_nan;
  logic                     o_ovf;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sign, o_int_bcd, o_frac_bcd,
           o_zero, o_inf, o_nan, o_ovf
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sign, o_int_bcd, o_frac_bcd,
           o_zero, o_inf, o_nan, o_ovf
  );
endinterface

// File: rtl/fp_to_bcd.sv
// IEEE-754 single-precision word to signed BCD digits.
// Iterative: double dabble over the integer bits, then one fraction digit
// per cycle by multiply-by-10. Fraction digits are truncated unless
// FP2BCD_ROUND_EN is defined, which adds a guard digit and a ROUND state.
module fp_to_bcd #(
  parameter int INT_BITS    = 16,
  parameter int INT_DIGITS  = 5,
  parameter int FRAC_BITS   = 24,
  parameter int FRAC_DIGITS = 4
) (
  input logic      i_clk,
  input logic      i_rst,
  fp_to_bcd_if.slave bus
);
  localparam int FW  = INT_BITS + FRAC_BITS;
  localparam int IBW = 4 * INT_DIGITS;
  localparam int FBW = 4 * FRAC_DIGITS;
`ifdef FP2BCD_ROUND_EN
  localparam int NFD = FRAC_DIGITS + 1;
`else
  localparam int NFD = FRAC_DIGITS;
`endif
  localparam logic [7:0] INT_LAST  = 8'(INT_BITS - 1);
  localparam logic [7:0] FRAC_LAST = 8'(NFD - 1);
  localparam logic [7:0] EXP_OVF   = 8'(127 + INT_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_INT, S_FRAC,
`ifdef FP2BCD_ROUND_EN
    S_ROUND,
`endif
    S_DONE
  } state_t;

  state_t               state_q;
  logic                 ready_q, valid_q, sign_q;
  logic                 zero_q, inf_q, nan_q, ovf_q;
  logic [30:0]          data_q;
  logic [INT_BITS-1:0]  int_q;
  logic [FRAC_BITS-1:0] frac_q;
  logic [IBW-1:0]       bcd_q;
  logic [FBW-1:0]       frac_bcd_q;
  logic [7:0]           cnt_q;
  logic [FW-1:0]        fixed_d;
  logic [FRAC_BITS+3:0] prod_d;
  logic [IBW-1:0]       dd_d;
`ifdef FP2BCD_ROUND_EN
  logic [3:0]           guard_q;
  logic [IBW+FBW:0]     inc_d;
`endif

  // {1,mant} * 2^(exp-127) as unsigned INT_BITS.FRAC_BITS, truncated below
  function automatic logic [FW-1:0] align_fixed(input logic [7:0] ex, input logic [22:0] mn);
    logic [FW+23:0] ext;
    int sh;
    ext = {{FW{1'b0}}, 1'b1, mn};
    sh  = int'(ex) - 127 + FRAC_BITS - 23;
    if (sh >= 0) ext = ext << sh;
    else         ext = ext >> (-sh);
    return ext[FW-1:0];
  endfunction

  // double-dabble pre-shift correction: +3 to every nibble >= 5
  function automatic logic [IBW-1:0] dd_adjust(input logic [IBW-1:0] b);
    logic [IBW-1:0] r;
    r = b;
    for (int k = 0; k < INT_DIGITS; k++)
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    return r;
  endfunction

`ifdef FP2BCD_ROUND_EN
  // decimal +1 ulp across all digits; MSB of the result is the carry out
  function automatic logic [IBW+FBW:0] bcd_inc(input logic [IBW+FBW-1:0] v);
    logic [IBW+FBW-1:0] r;
    logic               c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < INT_DIGITS + FRAC_DIGITS; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
        else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction
`endif

  // datapath helpers for the ALIGN, INT, FRAC and ROUND steps
  always_comb begin
    fixed_d = align_fixed(data_q[30:23], data_q[22:0]);
    prod_d  = ({4'd0, frac_q} << 3) + ({4'd0, frac_q} << 1);
    dd_d    = dd_adjust(bcd_q);
`ifdef FP2BCD_ROUND_EN
    inc_d   = bcd_inc({bcd_q, frac_bcd_q});
`endif
  end

  // conversion FSM with registered handshake, flags and digits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      inf_q      <= 1'b0;
      nan_q      <= 1'b0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
      int_q      <= '0;
      frac_q     <= '0;
      bcd_q      <= '0;
      frac_bcd_q <= '0;
      cnt_q      <= '0;
`ifdef FP2BCD_ROUND_EN
      guard_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid) begin
            data_q  <= bus.i_data[30:0];
            sign_q  <= bus.i_data[31];
            ready_q <= 1'b0;
            zero_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          cnt_q <= '0;
          if (data_q[30:23] == 8'd0 || data_q[30:23] == 8'd255) begin
            // specials: digits cleared, one flag set
            zero_q     <= (data_q[30:23] == 8'd0);
            inf_q      <= (data_q[30:23] == 8'd255) && (data_q[22:0] == 23'd0);
            nan_q      <= (data_q[30:23] == 8'd255) && (data_q[22:0] != 23'd0);
            bcd_q      <= '0;
            frac_bcd_q <= '0;
            valid_q    <= 1'b1;
            state_q    <= S_DONE;
          end else if (data_q[30:23] >= EXP_OVF) begin
            ovf_q      <= 1'b1;
            bcd_q      <= {INT_DIGITS{4'h9}};
            frac_bcd_q <= {FRAC_DIGITS{4'h9}};
            valid_q    <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            {int_q, frac_q} <= fixed_d;
            bcd_q      <= '0;
            frac_bcd_q <= '0;
            state_q    <= S_INT;
          end
        end
        S_INT: begin
          {bcd_q, int_q} <= {dd_d, int_q} << 1;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == INT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_FRAC;
          end
        end
        S_FRAC: begin
          frac_q <= prod_d[FRAC_BITS-1:0];
          cnt_q  <= cnt_q + 8'd1;
`ifdef FP2BCD_ROUND_EN
          if (cnt_q == FRAC_LAST) guard_q <= prod_d[FRAC_BITS +: 4];
          else frac_bcd_q <= FBW'({frac_bcd_q, prod_d[FRAC_BITS +: 4]});
          if (cnt_q == FRAC_LAST) state_q <= S_ROUND;
`else
          frac_bcd_q <= FBW'({frac_bcd_q, prod_d[FRAC_BITS +: 4]});
          if (cnt_q == FRAC_LAST) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
`endif
        end
`ifdef FP2BCD_ROUND_EN
        S_ROUND: begin
          if (guard_q >= 4'd5) begin
            if (inc_d[IBW+FBW]) begin
              ovf_q      <= 1'b1;
              bcd_q      <= {INT_DIGITS{4'h9}};
              frac_bcd_q <= {FRAC_DIGITS{4'h9}};
            end else begin
              {bcd_q, frac_bcd_q} <= inc_d[IBW+FBW-1:0];
            end
          end
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_sign     = sign_q;
  assign bus.o_int_bcd  = bcd_q;
  assign bus.o_frac_bcd = frac_bcd_q;
  assign bus.o_zero     = zero_q;
  assign bus.o_inf      = inf_q;
  assign bus.o_nan      = nan_q;
  assign bus.o_ovf      = ovf_q;
endmodule

// File: tb/tb_fp_to_bcd.sv
// Self-checking bench for fp_to_bcd: directed cases plus random words
// against a real-arithmetic decimal reference model.
module tb_fp_to_bcd;
  localparam int INT_BITS    = 16;
  localparam int INT_DIGITS  = 5;
  localparam int FRAC_BITS   = 24;
  localparam int FRAC_DIGITS = 4;
`ifdef FP2BCD_ROUND_EN
  localparam int NORM_LAT = INT_BITS + FRAC_DIGITS + 3;
`else
  localparam int NORM_LAT = INT_BITS + FRAC_DIGITS + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_to_bcd_if #(.INT_DIGITS(INT_DIGITS), .FRAC_DIGITS(FRAC_DIGITS)) bus ();

  fp_to_bcd #(
    .INT_BITS(INT_BITS), .INT_DIGITS(INT_DIGITS),
    .FRAC_BITS(FRAC_BITS), .FRAC_DIGITS(FRAC_DIGITS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic                     sign;
    logic [4*INT_DIGITS-1:0]  ib;
    logic [4*FRAC_DIGITS-1:0] fb;
    logic                     z, inf, nan, ovf;
    int                       lat;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // decimal value of the word, truncated to FRAC_BITS binary then to digits
  function automatic exp_t model(input logic [31:0] w);
    exp_t   r;
    real    mag;
    longint fx, ip, fr, fd, total, lim;
    int     ex;
    r.sign = w[31];
    r.z = 0; r.inf = 0; r.nan = 0; r.ovf = 0;
    r.lat = 1;
    total = 0;
    lim = pow10(INT_DIGITS + FRAC_DIGITS);
    ex = int'(w[30:23]);
    if (ex == 0) r.z = 1;
    else if (ex == 255) begin
      if (w[22:0] == 23'd0) r.inf = 1; else r.nan = 1;
    end else begin
      mag = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
      if (mag >= 2.0 ** INT_BITS) begin
        r.ovf = 1;
        total = lim - 1;
      end else begin
        r.lat = NORM_LAT;
        fx = longint'($floor(mag * (2.0 ** FRAC_BITS)));
        ip = fx / (longint'(1) << FRAC_BITS);
        fr = fx % (longint'(1) << FRAC_BITS);
        fd = (fr * pow10(FRAC_DIGITS)) / (longint'(1) << FRAC_BITS);
        total = ip * pow10(FRAC_DIGITS) + fd;
`ifdef FP2BCD_ROUND_EN
        if (((fr * pow10(FRAC_DIGITS + 1)) / (longint'(1) << FRAC_BITS)) % 10 >= 5)
          total = total + 1;
        if (total >= lim) begin
          r.ovf = 1;
          total = lim - 1;
        end
`endif
      end
    end
    for (int k = 0; k < FRAC_DIGITS; k++) begin
      r.fb[4*k +: 4] = 4'(total % 10);
      total = total / 10;
    end
    for (int k = 0; k < INT_DIGITS; k++) begin
      r.ib[4*k +: 4] = 4'(total % 10);
      total = total / 10;
    end
    return r;
  endfunction

  task automatic run(input logic [31:0] w, input int hold, input int pulse_at, input string tag);
    exp_t e;
    int   cyc;
    logic [31:0] junk;
    e = model(w);
    @(negedge clk);
    check({tag, ".rdy"}, 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = w;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    junk = $urandom;
    bus.i_data = junk;
    cyc = 0;
    while (bus.o_valid !== 1'b1 && cyc < 100) begin
      if (cyc == pulse_at) begin
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h3F800000;
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      cyc++;
    end
    check({tag, ".lat"}, 64'(cyc), 64'(e.lat));
    check({tag, ".sign"}, 64'(bus.o_sign), 64'(e.sign));
    check({tag, ".int"}, 64'(bus.o_int_bcd), 64'(e.ib));
    check({tag, ".frac"}, 64'(bus.o_frac_bcd), 64'(e.fb));
    check({tag, ".flags"}, 64'({bus.o_zero, bus.o_inf, bus.o_nan, bus.o_ovf}),
          64'({e.z, e.inf, e.nan, e.ovf}));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, ".hold"}, 64'({bus.o_valid, bus.o_ready, bus.o_int_bcd, bus.o_frac_bcd}),
            64'({1'b1, 1'b0, e.ib, e.fb}));
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({tag, ".hs"}, 64'({bus.o_valid, bus.o_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r32, w;
    logic [7:0]  ex;
    int          sel;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.hs", 64'({bus.o_valid, bus.o_ready}), 64'({1'b0, 1'b1}));
    check("reset.data", 64'({bus.o_sign, bus.o_int_bcd, bus.o_frac_bcd}), 64'd0);
    check("reset.flags", 64'({bus.o_zero, bus.o_inf, bus.o_nan, bus.o_ovf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run(32'h41C00000, 0, -1, "24.0");
    run(32'h40490FDB, 0, -1, "pi");
    run(32'h4498C70A, 0, -1, "1222.22");
    run(32'hC0200000, 0, -1, "-2.5");
    run(32'h7F800000, 0, -1, "inf");
    run(32'h7FC00000, 0, -1, "nan");
    run(32'h4788B800, 0, -1, "70000");
    run(32'h80000000, 0, -1, "-0");
    run(32'h3A800000, 0, -1, "tiny");
    run(32'h477FFF80, 0, -1, "max_int");
    run(32'h41C00000, 10, 5, "bp_pulse");

    // abort mid-INT with reset
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h41C00000;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort.hs", 64'({bus.o_valid, bus.o_ready}), 64'({1'b0, 1'b1}));
    check("abort.data", 64'({bus.o_int_bcd, bus.o_frac_bcd}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(32'h40000000, 0, -1, "after_abort");

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      r32 = $urandom;
      if (sel == 0)      ex = 8'd0;
      else if (sel == 1) ex = 8'd255;
      else               ex = 8'($urandom_range(105, 146));
      w = {r32[31], ex, r32[22:0]};
      run(w, $urandom_range(0, 3), -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
